// File: rtl/pic8259_pkg.sv
//------------------------------------------------------------------------------
// Package: pic8259_pkg
// Purpose: Shared types and constants for the 8259A-style interrupt path
//          (acknowledge sequencer and priority resolver).
// Contents:
//   ack_state_t     acknowledge-sequencer FSM states
//   level_t         3-bit interrupt level
//   EOI_NONSPECIFIC eoi_specific encoding for "clear highest in service"
//   EOI_SPECIFIC    eoi_specific encoding for "clear ISR[eoi_level]"
//   SPURIOUS_LEVEL  level reported when a request vanishes before INTA#
//   level_to_mask() level -> one-hot 8-bit mask
//------------------------------------------------------------------------------
package pic8259_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ACK1,
      GAP,
      ACK2
   } ack_state_t;

   typedef logic [2:0] level_t;

   localparam logic   EOI_NONSPECIFIC = 1'b0;
   localparam logic   EOI_SPECIFIC    = 1'b1;
   localparam level_t SPURIOUS_LEVEL  = 3'd7;

   function automatic logic [7:0] level_to_mask(input level_t lvl);
      return 8'b0000_0001 << lvl;
   endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_encoder.sv
//------------------------------------------------------------------------------
// Module: lowest_bit_encoder8
// Purpose: Encodes the lowest-index set bit of an 8-bit vector. Lowest index is
//          highest priority throughout the interrupt path, so this single
//          encoder serves acknowledge capture, non-specific EOI and the
//          highest-level-in-service report.
// Ports:
//   i_bits   in   8  vector to encode
//   o_index  out  3  index of the lowest set bit (0 when none set)
//   o_valid  out  1  1 = at least one bit of i_bits is set
//------------------------------------------------------------------------------
module lowest_bit_encoder8
   import pic8259_pkg::*;
(
   input  logic [7:0] i_bits,
   output level_t     o_index,
   output logic       o_valid
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned; without this the tool infers a latch.
      o_index = '0;
      o_valid = 1'b0;
      // Walk from the top down so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--) begin
         if (i_bits[i]) begin
            o_index = level_t'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
//------------------------------------------------------------------------------
// Module: interrupt_ack_sequencer
// Purpose: CPU-facing end of an 8259A-style interrupt path. Raises int_out for
//          a pending request, runs the two-pulse INTA# acknowledge, owns the
//          in-service register (ISR), drives the 8-bit vector and processes
//          EOI commands.
// Configuration macro:
//   AUTO_EOI_EN  defined   : ISR[level] is cleared on the ACK2 -> IDLE step,
//                            the same cycle ack_done pulses.
//                undefined : ISR bits are cleared only by EOI commands.
// Parameters:
//   VECTOR_W    vector bus width, must be 8
//   SPURIOUS_L  level reported for a spurious acknowledge (0..7)
// Ports:
//   clock                     in   1  rising-edge clock
//   reset                     in   1  asynchronous, active-high
//   interrupt                 in   8  one-hot winner from the priority resolver
//   irq_pending               in   1  1 = interrupt is a real pending request
//   inta_n                    in   1  CPU acknowledge strobe, active-low
//   vector_base               in   5  ICW2 T7..T3
//   eoi_valid                 in   1  one-cycle EOI command strobe
//   eoi_specific              in   1  1 = specific EOI, 0 = non-specific
//   eoi_level                 in   3  level for a specific EOI
//   int_out                   out  1  interrupt request to the CPU
//   vector_out                out  8  {vector_base, level}
//   vector_oe                 out  1  data-bus drive enable for vector_out
//   in_service_register       out  8  ISR
//   highest_level_in_service  out  8  one-hot of lowest set ISR bit, 0 if empty
//   ack_done                  out  1  one-cycle pulse at end of acknowledge
//------------------------------------------------------------------------------
module interrupt_ack_sequencer
   import pic8259_pkg::*;
#(
   parameter int VECTOR_W   = 8,
   parameter int SPURIOUS_L = int'(SPURIOUS_LEVEL)
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          interrupt,
   input  logic                irq_pending,
   input  logic                inta_n,
   input  logic [4:0]          vector_base,
   input  logic                eoi_valid,
   input  logic                eoi_specific,
   input  level_t              eoi_level,
   output logic                int_out,
   output logic [VECTOR_W-1:0] vector_out,
   output logic                vector_oe,
   output logic [7:0]          in_service_register,
   output logic [7:0]          highest_level_in_service,
   output logic                ack_done
);

   generate
      if (VECTOR_W != 8) begin : g_bad_vector_w
         $error("interrupt_ack_sequencer: VECTOR_W must be 8");
      end
      if (SPURIOUS_L < 0 || SPURIOUS_L > 7) begin : g_bad_spurious_l
         $error("interrupt_ack_sequencer: SPURIOUS_L must be 0..7");
      end
   endgenerate

   localparam level_t SPUR_LVL = level_t'(SPURIOUS_L);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   ack_state_t          r_state;
   logic                r_inta_q;
   level_t              r_level;
   logic                r_spurious;
   logic [7:0]          r_isr;
   logic                r_int_out;
   logic                r_vector_oe;
   logic [VECTOR_W-1:0] r_vector_out;
   logic                r_ack_done;

   //---------------------------------------------------------------------------
   // INTA# edge detection against the registered copy
   //---------------------------------------------------------------------------
   logic w_fall;
   logic w_rise;

   assign w_fall = r_inta_q & ~inta_n;
   assign w_rise = ~r_inta_q & inta_n;

   //---------------------------------------------------------------------------
   // Encoders: one on the resolver winner, one on the ISR
   //---------------------------------------------------------------------------
   level_t w_req_level;
   logic   w_req_valid;
   level_t w_isr_level;
   logic   w_isr_valid;

   lowest_bit_encoder8 u_ack_enc (
      .i_bits  (interrupt),
      .o_index (w_req_level),
      .o_valid (w_req_valid)
   );

   lowest_bit_encoder8 u_isr_enc (
      .i_bits  (r_isr),
      .o_index (w_isr_level),
      .o_valid (w_isr_valid)
   );

   //---------------------------------------------------------------------------
   // Acknowledge capture. A first INTA# fall is honoured in IDLE as well as
   // REQ: once the CPU has started an acknowledge it is committed to reading a
   // vector, so a request that vanished before the fall still gets the
   // spurious level rather than leaving the bus undriven.
   //---------------------------------------------------------------------------
   logic w_ack_take;
   logic w_ack_real;

   assign w_ack_take = w_fall & ((r_state == IDLE) | (r_state == REQ));
   assign w_ack_real = w_ack_take & irq_pending & w_req_valid;

   //---------------------------------------------------------------------------
   // ISR next-state: clears first, then the acknowledge set, so a set and a
   // clear of the same bit in one cycle leaves the bit set.
   //---------------------------------------------------------------------------
   logic [7:0] w_set_mask;
   logic [7:0] w_eoi_mask;
   logic [7:0] w_auto_mask;
   logic [7:0] w_isr_next;

   assign w_set_mask = w_ack_real ? level_to_mask(w_req_level) : 8'h00;

   always_comb begin
      w_eoi_mask = 8'h00;
      if (eoi_valid) begin
         if (eoi_specific == EOI_SPECIFIC) begin
            w_eoi_mask = level_to_mask(eoi_level);
         end else if (w_isr_valid) begin
            w_eoi_mask = level_to_mask(w_isr_level);
         end
      end
   end

`ifdef AUTO_EOI_EN
   // A spurious acknowledge never set a bit, so it must not clear one either.
   assign w_auto_mask = ((r_state == ACK2) && w_rise && !r_spurious)
                        ? level_to_mask(r_level) : 8'h00;
`else
   assign w_auto_mask = 8'h00;
`endif

   assign w_isr_next = (r_isr & ~(w_eoi_mask | w_auto_mask)) | w_set_mask;

   //---------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   //---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_inta_q     <= 1'b1;
         r_level      <= '0;
         r_spurious   <= 1'b0;
         r_isr        <= 8'h00;
         r_int_out    <= 1'b0;
         r_vector_oe  <= 1'b0;
         r_vector_out <= '0;
         r_ack_done   <= 1'b0;
      end else begin
         r_inta_q   <= inta_n;
         r_isr      <= w_isr_next;
         r_ack_done <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state    <= ACK1;
                  r_level    <= w_ack_real ? w_req_level : SPUR_LVL;
                  r_spurious <= ~w_ack_real;
               end else if (irq_pending) begin
                  r_state   <= REQ;
                  r_int_out <= 1'b1;
               end
            end

            REQ: begin
               if (w_fall) begin
                  r_state    <= ACK1;
                  r_level    <= w_ack_real ? w_req_level : SPUR_LVL;
                  r_spurious <= ~w_ack_real;
                  r_int_out  <= 1'b0;
               end else if (!irq_pending) begin
                  r_state   <= IDLE;
                  r_int_out <= 1'b0;
               end
            end

            ACK1: begin
               if (w_rise) begin
                  r_state <= GAP;
               end
            end

            GAP: begin
               if (w_fall) begin
                  r_state      <= ACK2;
                  r_vector_oe  <= 1'b1;
                  r_vector_out <= {vector_base, r_level};
               end
            end

            ACK2: begin
               if (w_rise) begin
                  r_state     <= IDLE;
                  r_vector_oe <= 1'b0;
                  r_ack_done  <= 1'b1;
               end
            end

            default: begin
               r_state   <= IDLE;
               r_int_out <= 1'b0;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign int_out                  = r_int_out;
   assign vector_out               = r_vector_out;
   assign vector_oe                = r_vector_oe;
   assign in_service_register      = r_isr;
   assign ack_done                 = r_ack_done;
   assign highest_level_in_service = w_isr_valid ? level_to_mask(w_isr_level) : 8'h00;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
`timescale 1ns/1ps
module tb_interrupt_ack_sequencer;

`ifdef AUTO_EOI_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] interrupt;
   logic       irq_pending;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] vector_out;
   logic       vector_oe;
   logic [7:0] in_service_register;
   logic [7:0] highest_level_in_service;
   logic       ack_done;

   always #5 clock = ~clock;

   interrupt_ack_sequencer dut (
      .clock                    (clock),
      .reset                    (reset),
      .interrupt                (interrupt),
      .irq_pending              (irq_pending),
      .inta_n                   (inta_n),
      .vector_base              (vector_base),
      .eoi_valid                (eoi_valid),
      .eoi_specific             (eoi_specific),
      .eoi_level                (eoi_level),
      .int_out                  (int_out),
      .vector_out               (vector_out),
      .vector_oe                (vector_oe),
      .in_service_register      (in_service_register),
      .highest_level_in_service (highest_level_in_service),
      .ack_done                 (ack_done)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] vec_obs[$];
   int         ack_cnt  = 0;
   bit         oe_prev  = 1'b0;

   // Reference vector: lowest set request bit, or level 7 when no real request.
   function automatic logic [7:0] model_vector(input logic [4:0] base,
                                               input logic [7:0] irq,
                                               input logic       pend);
      logic [2:0] lvl;
      lvl = 3'd7;
      if (pend && irq != 8'h00) begin
         for (int i = 7; i >= 0; i--) begin
            if (irq[i]) lvl = i[2:0];
         end
      end
      return {base, lvl};
   endfunction

   // Advance one clock, sample 1 ns after the edge and record DUT events.
   task automatic step();
      @(posedge clock);
      #1;
      if (ack_done === 1'b1) ack_cnt++;
      if (vector_oe === 1'b1 && !oe_prev) vec_obs.push_back(vector_out);
      oe_prev = (vector_oe === 1'b1);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      interrupt    = 8'h00;
      irq_pending  = 1'b0;
      inta_n       = 1'b1;
      vector_base  = 5'h10;
      eoi_valid    = 1'b0;
      eoi_specific = 1'b0;
      eoi_level    = 3'd0;
      step();
      step();
      reset = 1'b0;
      step();
      ack_cnt = 0;
      oe_prev = 1'b0;
      vec_obs.delete();
      exp_q.delete();
   endtask

   // Two INTA# pulses (low 2 cycles, high 2 cycles). Optionally stops in GAP,
   // optionally issues a specific EOI on the first-fall cycle.
   task automatic run_ack(input  bit         stop_at_gap,
                          input  bit         eoi_at_fall,
                          input  logic [2:0] eoi_lvl,
                          output logic [7:0] isr_fall,
                          output logic       int_fall,
                          output logic       oe_ack2,
                          output logic [7:0] isr_ack2,
                          output logic [7:0] isr_done);
      inta_n = 1'b0;
      if (eoi_at_fall) begin
         eoi_valid    = 1'b1;
         eoi_specific = 1'b1;
         eoi_level    = eoi_lvl;
      end
      step();
      isr_fall    = in_service_register;
      int_fall    = int_out;
      eoi_valid   = 1'b0;
      irq_pending = 1'b0;
      interrupt   = 8'h00;
      step();
      inta_n = 1'b1;
      step();
      step();
      oe_ack2  = 1'bx;
      isr_ack2 = 8'hxx;
      isr_done = 8'hxx;
      if (!stop_at_gap) begin
         inta_n = 1'b0;
         step();
         oe_ack2  = vector_oe;
         isr_ack2 = in_service_register;
         step();
         inta_n = 1'b1;
         step();
         isr_done = in_service_register;
         step();
      end
   endtask

   task automatic request(input logic [7:0] irq);
      irq_pending = 1'b1;
      interrupt   = irq;
      exp_q.push_back(model_vector(vector_base, irq, 1'b1));
      step();
   endtask

   //---------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      interrupt = 8'h00; irq_pending = 1'b0; inta_n = 1'b1; vector_base = 5'h10;
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      #12;
      n_checks++;
      if ({int_out, vector_oe, ack_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 000", {int_out, vector_oe, ack_done});
      end
      n_checks++;
      if ({vector_out, in_service_register, highest_level_in_service} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 000000",
                  {vector_out, in_service_register, highest_level_in_service});
      end
      do_reset();
   endtask

   task automatic test_basic_ack();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      logic [7:0] e, o;
      do_reset();
      request(8'h08);
      n_checks++;
      if (int_out !== 1'b1) begin
         n_fail++; $display("FAIL basic_int_out: got %b required 1", int_out);
      end
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h08 || int_f !== 1'b0) begin
         n_fail++; $display("FAIL basic_fall: got isr %h int %b required 08 0", isr_f, int_f);
      end
      n_checks++;
      if (oe_a !== 1'b1) begin
         n_fail++; $display("FAIL basic_oe_latency: got %b required 1", oe_a);
      end
      n_checks++;
      if (ack_cnt !== 1) begin
         n_fail++; $display("FAIL basic_ack_done: got %0d pulses required 1", ack_cnt);
      end
      n_checks++;
      if (highest_level_in_service !== (AUTO ? 8'h00 : 8'h08)) begin
         n_fail++; $display("FAIL basic_hlis: got %h required %h",
                            highest_level_in_service, AUTO ? 8'h00 : 8'h08);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (vec_obs.size() > 0) ? vec_obs.pop_front() : 8'hxx;
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL basic_vector: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_spurious();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      logic [7:0] e, o;
      do_reset();
      irq_pending = 1'b1;
      interrupt   = 8'h04;
      step();
      irq_pending = 1'b0;
      interrupt   = 8'h00;
      step();
      n_checks++;
      if (int_out !== 1'b0) begin
         n_fail++; $display("FAIL spur_int_out: got %b required 0", int_out);
      end
      exp_q.push_back(model_vector(vector_base, 8'h00, 1'b0));
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h00 || isr_d !== 8'h00) begin
         n_fail++; $display("FAIL spur_isr: got %h/%h required 00/00", isr_f, isr_d);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (vec_obs.size() > 0) ? vec_obs.pop_front() : 8'hxx;
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL spur_vector: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_eoi();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      logic [7:0] e, o;
      do_reset();
      request(8'h04);
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      request(8'h20);
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (in_service_register !== (AUTO ? 8'h00 : 8'h24)) begin
         n_fail++; $display("FAIL eoi_isr_built: got %h required %h",
                            in_service_register, AUTO ? 8'h00 : 8'h24);
      end
      n_checks++;
      if (highest_level_in_service !== (AUTO ? 8'h00 : 8'h04)) begin
         n_fail++; $display("FAIL eoi_hlis: got %h required %h",
                            highest_level_in_service, AUTO ? 8'h00 : 8'h04);
      end
      eoi_valid = 1'b1; eoi_specific = 1'b0;
      step();
      eoi_valid = 1'b0;
      n_checks++;
      if (in_service_register !== (AUTO ? 8'h00 : 8'h20)) begin
         n_fail++; $display("FAIL eoi_nonspecific: got %h required %h",
                            in_service_register, AUTO ? 8'h00 : 8'h20);
      end
      eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5;
      step();
      eoi_valid = 1'b0;
      n_checks++;
      if (in_service_register !== 8'h00) begin
         n_fail++; $display("FAIL eoi_specific: got %h required 00", in_service_register);
      end
      eoi_valid = 1'b1; eoi_specific = 1'b0;
      step();
      eoi_specific = 1'b1; eoi_level = 3'd3;
      step();
      eoi_valid = 1'b0;
      n_checks++;
      if (in_service_register !== 8'h00) begin
         n_fail++; $display("FAIL eoi_empty: got %h required 00", in_service_register);
      end
      // Same bit set and cleared in one cycle: set wins.
      request(8'h08);
      run_ack(1'b0, 1'b1, 3'd3, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h08) begin
         n_fail++; $display("FAIL eoi_set_wins: got %h required 08", isr_f);
      end
      // Different bits in one cycle: both apply.
      request(8'h02);
      run_ack(1'b0, 1'b1, 3'd3, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h02) begin
         n_fail++; $display("FAIL eoi_both_apply: got %h required 02", isr_f);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (vec_obs.size() > 0) ? vec_obs.pop_front() : 8'hxx;
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL eoi_vector: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      logic [7:0] e, o;
      do_reset();
      irq_pending = 1'b1;
      interrupt   = 8'h10;
      step();
      run_ack(1'b1, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h10) begin
         n_fail++; $display("FAIL rmid_isr_before: got %h required 10", isr_f);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (vector_oe !== 1'b0 || in_service_register !== 8'h00) begin
         n_fail++; $display("FAIL rmid_async: got oe %b isr %h required 0 00",
                            vector_oe, in_service_register);
      end
      step();
      reset = 1'b0;
      step();
      n_checks++;
      if (int_out !== 1'b0 || in_service_register !== 8'h00 || ack_cnt !== 0) begin
         n_fail++; $display("FAIL rmid_idle: got int %b isr %h acks %0d required 0 00 0",
                            int_out, in_service_register, ack_cnt);
      end
      request(8'h02);
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h02 || ack_cnt !== 1) begin
         n_fail++; $display("FAIL rmid_reack: got isr %h acks %0d required 02 1", isr_f, ack_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (vec_obs.size() > 0) ? vec_obs.pop_front() : 8'hxx;
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL rmid_vector: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_multi_bit();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      logic [7:0] e, o;
      do_reset();
      vector_base = 5'h1A;
      request(8'h81);
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_f !== 8'h01) begin
         n_fail++; $display("FAIL multi_isr: got %h required 01", isr_f);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (vec_obs.size() > 0) ? vec_obs.pop_front() : 8'hxx;
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL multi_vector: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_auto_eoi();
      logic [7:0] isr_f, isr_a, isr_d;
      logic       int_f, oe_a;
      do_reset();
      request(8'h04);
      run_ack(1'b0, 1'b0, 3'd0, isr_f, int_f, oe_a, isr_a, isr_d);
      n_checks++;
      if (isr_a !== 8'h04) begin
         n_fail++; $display("FAIL auto_isr_ack2: got %h required 04", isr_a);
      end
      n_checks++;
      if (isr_d !== (AUTO ? 8'h00 : 8'h04) || ack_cnt !== 1) begin
         n_fail++; $display("FAIL auto_isr_done: got %h acks %0d required %h 1",
                            isr_d, ack_cnt, AUTO ? 8'h00 : 8'h04);
      end
   endtask

   initial begin
      test_reset();
      test_basic_ack();
      test_spurious();
      test_eoi();
      test_reset_mid();
      test_multi_bit();
      test_auto_eoi();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
